// File: rtl/factorial_inverse_blk.sv
// Inverse-factorial search: finds n in 1..15 with n! == in_data, building k! one multiply per cycle.
// Optional macro FACT_INV_FLOOR_EN: on no match, out_n reports the floor index instead of 0.
module factorial_inverse_blk (
  input  logic        clk,
  input  logic        resetn,
  input  logic [45:0] in_data,
  input  logic        in_valid,
  output logic [3:0]  out_n,
  output logic        out_match,
  output logic        out_valid,
  output logic        out_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [45:0] target_q, target_d;
  logic [45:0] prod_q, prod_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  out_n_q, out_n_d;
  logic        out_match_q, out_match_d;
  logic        out_valid_q, out_valid_d;
  logic        out_busy_q, out_busy_d;

  logic [45:0] k_inc_ext;
  logic [3:0]  nomatch_n;
  logic        prod_gt;

  assign prod_gt   = (prod_q > target_q);
  assign k_inc_ext = {42'd0, k_q + 4'd1};

`ifdef FACT_INV_FLOOR_EN
  // prod_q overshot: floor is the previous index; otherwise k hit 15 with prod still <= target.
  assign nomatch_n = prod_gt ? (k_q - 4'd1) : k_q;
`else
  assign nomatch_n = 4'd0;
`endif

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    prod_d      = prod_q;
    k_d         = k_q;
    out_n_d     = out_n_q;
    out_match_d = out_match_q;
    out_valid_d = out_valid_q;
    out_busy_d  = out_busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          target_d    = in_data;
          prod_d      = 46'd1;
          k_d         = 4'd1;
          out_busy_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (prod_q == target_q) begin
          out_match_d = 1'b1;
          out_n_d     = k_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (prod_gt || (k_q == 4'd15)) begin
          out_match_d = 1'b0;
          out_n_d     = nomatch_n;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          // 15! < 2^46, so the truncation never discards bits.
          prod_d = prod_q * k_inc_ext;
          k_d    = k_q + 4'd1;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b0;
        out_busy_d  = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      target_q    <= 46'd0;
      prod_q      <= 46'd0;
      k_q         <= 4'd0;
      out_n_q     <= 4'd0;
      out_match_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      prod_q      <= prod_d;
      k_q         <= k_d;
      out_n_q     <= out_n_d;
      out_match_q <= out_match_d;
      out_valid_q <= out_valid_d;
      out_busy_q  <= out_busy_d;
    end
  end

  assign out_n     = out_n_q;
  assign out_match = out_match_q;
  assign out_valid = out_valid_q;
  assign out_busy  = out_busy_q;

endmodule

// File: tb/tb_factorial_inverse_blk.sv
// Bench for factorial_inverse_blk: randomized requests, reference model, scoreboard with cycle-exact timing.
module tb_factorial_inverse_blk;

  localparam int EW = 37;  // {expected cycle[31:0], match, n[3:0]}

  logic        clk = 1'b0;
  logic        resetn;
  logic [45:0] in_data;
  logic        in_valid;
  logic [3:0]  out_n;
  logic        out_match;
  logic        out_valid;
  logic        out_busy;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [45:0] fact[16];
  logic [3:0]  last_n;
  logic        last_m;

  factorial_inverse_blk dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_n    (out_n),
    .out_match(out_match),
    .out_valid(out_valid),
    .out_busy (out_busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain search over the factorial table.
  function automatic void model(input logic [45:0] v, output logic [3:0] n,
                                output logic m, output int d);
    int fl;
    m  = 1'b0;
    n  = 4'd0;
    fl = 0;
    for (int k = 1; k <= 15; k++) begin
      if (fact[k] == v) begin
        m = 1'b1;
        n = 4'(k);
      end
      if (fact[k] <= v) fl = k;
    end
    if (m) d = int'(n);
    else if (v == 46'd0) d = 1;
    else if (v > fact[15]) d = 15;
    else d = fl + 1;
`ifdef FACT_INV_FLOOR_EN
    if (!m) n = 4'(fl);
`endif
  endfunction

  // driver: one request, busy timing checked here, result checked by monitor
  task automatic send(input logic [45:0] v);
    logic [3:0]  n;
    logic        m;
    int          d;
    int unsigned c0;
    int          cnt;
    model(v, n, m, d);
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back({c0 + 32'(d), m, n});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 46'(($urandom_range(0, 1000)));
    check("busy_after_accept", out_busy, 1);
    check("n_hold_on_accept", out_n, last_n);
    check("match_hold_on_accept", out_match, last_m);
    cnt = 0;
    while (out_busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_timeout", cnt < 40, 1);
    check("busy_fall_cycle", cyc, c0 + 32'(d) + 1);
    last_n = n;
    last_m = m;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_n", out_n, e[3:0]);
        check("out_match", out_match, e[4]);
        check("valid_cycle", cyc, e[36:5]);
        check("busy_with_valid", out_busy, 1);
      end
    end
  end

  initial begin
    logic [45:0] v;
    int unsigned c0;
    fact[0] = 46'd1;
    for (int k = 1; k < 16; k++) fact[k] = fact[k-1] * 46'(k);

    // reset
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 46'd0;
    last_n   = 4'd0;
    last_m   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_n", out_n, 0);
    check("rst_out_match", out_match, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_busy", out_busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    // directed cases
    send(46'd120);
    send(46'd1);
    send(46'd1307674368000);
    send(46'd121);
    send(46'd0);
    send({46{1'b1}});
    send(46'd1307674368001);
    send(46'd1307674367999);

    // randomized: exact factorials, neighbours, and raw values
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: v = fact[k];
        1: v = fact[k] + 46'd1;
        2: v = fact[k] - 46'd1;
        default: v = {14'($urandom), $urandom} >> $urandom_range(0, 45);
      endcase
      send(v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // in_valid held high: one 720 result, then re-acceptance at E8
    @(negedge clk);
    in_data  = 46'd720;
    in_valid = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back({c0 + 32'd6, 1'b1, 4'd6});
    exp_q.push_back({c0 + 32'd14, 1'b1, 4'd6});
    while (cyc != c0 + 7) @(negedge clk);
    check("held_busy_low_e7", out_busy, 0);
    @(negedge clk);
    check("held_reaccept_e8", out_busy, 1);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("held_busy_done", out_busy, 0);
    check("held_queue_empty", exp_q.size(), 0);
    last_n = 4'd6;
    last_m = 1'b1;

    // reset pulsed at E3 of a 720 request: outputs clear, no result follows
    @(negedge clk);
    in_data  = 46'd720;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("abort_out_n", out_n, 0);
    check("abort_out_match", out_match, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_busy", out_busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    last_n = 4'd0;
    last_m = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_busy_idle", out_busy, 0);

    // normal operation after abort
    send(46'd5040);
    send(46'd5041);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/factorial_inverse_blk.md
# factorial_inverse_blk

Inverse-factorial search engine: accepts a 46-bit value and reports whether it equals n! for some n in 1..15, and if so which n. Sits alongside the factorial block on the same valid/busy interface style and checks factorial results in the math datapath. It builds k! by iterative multiplication, one multiply/compare per cycle. The result is held until the next accepted request.

## Interface
- Parameters: none. Widths are fixed: 46-bit operand and 4-bit result. 15! = 1307674368000 < 2^46, so every intermediate product fits.
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_data  in  46  candidate value, sampled on acceptance
- in_valid  in  1  request strobe; accepted only in IDLE
- out_n  out  4  result index (see Operation)
- out_match  out  1  1 = in_data was exactly out_n!
- out_valid  out  1  one-cycle result strobe
- out_busy  out  1  1 = request in progress; in_valid ignored

## Operation
- States:
  - IDLE: waiting for a request.
  - SEARCH: one compare/multiply step per cycle.
  - DONE: one-cycle result presentation.
- Internal registers:
  - target: 46 bits.
  - prod: 46 bits, holds k!.
  - k: 4 bits.
- IDLE with in_valid=1:
  - target<=in_data, prod<=1, k<=1.
  - out_busy<=1, out_valid<=0.
  - Go to SEARCH.
- IDLE with in_valid=0: hold state; all outputs hold.
- Each SEARCH cycle evaluates the following in priority order:
  - prod==target: match. out_match<=1, out_n<=k, go to DONE.
  - prod>target: no match; go to DONE.
  - k==15: no match; go to DONE.
  - Otherwise: prod<=prod*(k+1), truncated to 46 bits (never overflows); k<=k+1; stay in SEARCH.
- No-match result: out_match<=0, out_n<=0. This changes with the macro; see Configuration.
- DONE: out_valid=1 and out_busy=1 for exactly one cycle, then IDLE with out_valid<=0 and out_busy<=0.
- in_valid is ignored in SEARCH and DONE. There is no queueing, so a dropped request must be re-presented.
- Value 1 (0! = 1! = 1) reports out_n=1 with out_match=1.
- Value 0: no match.
- out_n and out_match hold from the DONE entry until the next decision. They do not clear on acceptance.

## Timing
- Reset values: out_n=0, out_match=0, out_valid=0, out_busy=0, state IDLE.
- Reset asserted mid-SEARCH or in DONE aborts immediately to reset values. The in-flight request is lost.
- Edge numbering: the acceptance edge is E0. The decision edge is Ed, where d = number of SEARCH cycles.
  - out_valid is high in the cycle following Ed and low after E(d+1).
  - out_busy rises after E0 and falls after E(d+1).
- Values of d:
  - Exact n!: d=n.
  - k! < value < (k+1)!, with k<15: d=k+1.
  - Value 0: d=1.
  - Value > 15!: d=15.
- Earliest re-acceptance: edge E(d+2), since in_valid is sampled in IDLE.
- Worst-case request-to-request interval: 17 cycles.

## Configuration
- Macro: FACT_INV_FLOOR_EN.
- Defined: on no match, out_n reports the floor index, i.e. the largest k with k! <= value.
  - Value 0 gives 0.
  - Value > 15! gives 15.
  - Otherwise gives k, the index of the last product that was <= target.
  - out_match stays 0.
- Undefined: on no match, out_n=0.
- Match behaviour and all timing are identical in both builds.

## Test plan
- Reset, then in_data=120 with in_valid for 1 cycle:
  - out_busy=1 after E0.
  - out_valid pulse after E5 with out_n=5, out_match=1.
  - out_busy=0 after E6.
- in_data=1 -> out_n=1, out_match=1, d=1.
- in_data=1307674368000 (15!) -> out_n=15, out_match=1, d=15.
- in_data=121 -> out_match=0, d=6.
  - out_n=0 without the macro.
  - out_n=5 with FACT_INV_FLOOR_EN.
- Boundary values:
  - in_data=0 -> out_match=0, d=1.
  - in_data=2^46-1 -> out_match=0, d=15; out_n=15 with the macro, 0 without.
- Mid-operation events:
  - in_valid held high throughout the 720 request: exactly one result (out_n=6), then a new acceptance at E8.
  - resetn pulsed low at E3 of the same request: all outputs go to 0 immediately and no out_valid pulse follows.
